// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM between NUM_REQ renderers.
// Bounded bursts allow back-to-back row fetches; read data returns tagged by a one-hot valid.
module sprite_rom_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_BITS   = 14,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rd_valid,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rom_en,
  output logic [ADDR_BITS-1:0]           rom_addr,
  input  logic [DATA_WIDTH-1:0]          rom_data
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW  = $clog2(MAX_BURST + 1);
  localparam int unsigned PipeW = ROM_LATENCY * NUM_REQ;
  localparam logic [CntW-1:0] MaxBurst = CntW'(MAX_BURST);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);

  logic                 r_owner_valid;
  logic [IdxW-1:0]      r_owner;
  logic [IdxW-1:0]      r_rr_ptr;
  logic [CntW-1:0]      r_beat_cnt;
  logic [ADDR_BITS-1:0] r_rom_addr;
  logic [PipeW-1:0]     r_ret_pipe;

  logic                 w_keep;
  logic                 w_scan_hit;
  logic                 w_any;
  logic [IdxW-1:0]      w_cand;
  logic [IdxW-1:0]      w_scan_idx;
  logic [IdxW-1:0]      w_win;
  logic [NUM_REQ-1:0]   w_gnt;

  assign w_keep = r_owner_valid && req[r_owner] && (r_beat_cnt < MaxBurst);

  // Scan starts just after the last burst winner, so an expired owner comes last.
  always_comb begin
    w_scan_hit = 1'b0;
    w_scan_idx = '0;
    w_cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IdxW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_scan_hit && req[w_cand]) begin
        w_scan_hit = 1'b1;
        w_scan_idx = w_cand;
      end
    end
  end

  assign w_win  = w_keep ? r_owner : w_scan_idx;
  assign w_any  = w_keep | w_scan_hit;
  assign w_gnt  = w_any ? (NUM_REQ'(1) << w_win) : '0;

  assign gnt      = w_gnt;
  assign rom_en   = w_any;
  assign rom_addr = w_any ? req_addr[32'(w_win) * ADDR_BITS +: ADDR_BITS] : r_rom_addr;

  assign rd_valid = r_ret_pipe[(ROM_LATENCY - 1) * NUM_REQ +: NUM_REQ];
  assign rd_data  = rom_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_valid <= 1'b0;
      r_owner       <= '0;
      r_beat_cnt    <= '0;
      r_rr_ptr      <= LastIdx;
      r_rom_addr    <= '0;
      r_ret_pipe    <= '0;
    end else begin
      r_rom_addr <= rom_addr;
      r_ret_pipe <= (r_ret_pipe << NUM_REQ) | PipeW'(w_gnt);
      if (w_keep) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end else if (w_any) begin
        r_owner       <= w_win;
        r_owner_valid <= 1'b1;
        r_beat_cnt    <= CntW'(1);
        r_rr_ptr      <= w_win;
      end else begin
        r_owner_valid <= 1'b0;
        r_beat_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed vector table, hand sequences for
// burst/reset/latency corners, and randomized traffic against a behavioural model.
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters (MAX_BURST=4, ROM_LATENCY=1)
  logic [N-1:0]    a_req, a_gnt, a_rv;
  logic [N*AW-1:0] a_addr;
  logic [DW-1:0]   a_rdata, a_rom_data;
  logic            a_rom_en;
  logic [AW-1:0]   a_rom_addr;

  // Instance B: MAX_BURST=1, ROM_LATENCY=3
  logic [N-1:0]    b_req, b_gnt, b_rv;
  logic [N*AW-1:0] b_addr;
  logic [DW-1:0]   b_rdata, b_rom_data;
  logic            b_rom_en;
  logic [AW-1:0]   b_rom_addr;

  sprite_rom_arbiter #(
    .NUM_REQ(N), .ADDR_BITS(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .ROM_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .req_addr(a_addr), .gnt(a_gnt),
    .rd_valid(a_rv), .rd_data(a_rdata), .rom_en(a_rom_en), .rom_addr(a_rom_addr),
    .rom_data(a_rom_data)
  );

  sprite_rom_arbiter #(
    .NUM_REQ(N), .ADDR_BITS(AW), .DATA_WIDTH(DW), .MAX_BURST(1), .ROM_LATENCY(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .req_addr(b_addr), .gnt(b_gnt),
    .rd_valid(b_rv), .rd_data(b_rdata), .rom_en(b_rom_en), .rom_addr(b_rom_addr),
    .rom_data(b_rom_data)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[13:6] ^ 8'h5A;
  endfunction

  // Synchronous ROM models with 1 and 3 cycles of read latency
  logic [AW-1:0] a_rom_q;
  logic [AW-1:0] b_rom_q0, b_rom_q1, b_rom_q2;
  always @(posedge clk) begin
    a_rom_q  <= a_rom_addr;
    b_rom_q0 <= b_rom_addr;
    b_rom_q1 <= b_rom_q0;
    b_rom_q2 <= b_rom_q1;
  end
  assign a_rom_data = rom_f(a_rom_q);
  assign b_rom_data = rom_f(b_rom_q2);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = '0;
    b_req = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset gnt", 32'(a_gnt), 0);
    chk("reset rd_valid", 32'(a_rv), 0);
    chk("reset rom_en", 32'(a_rom_en), 0);
    chk("reset rom_addr", 32'(a_rom_addr), 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] rv;
  } vec_t;

  vec_t          tbl[$];
  logic [AW-1:0] fa[N];
  logic [AW-1:0] exp_last;
  logic [AW-1:0] b_cur[N];
  logic [AW-1:0] ta[6];

  // Behavioural model state for randomized traffic
  int            m_last, m_run, m_ptr, wi;
  bit            m_keep;
  logic [N-1:0]  m_rv, eg, prev_gnt;
  logic [AW-1:0] m_raddr, m_alast, eaddr;
  logic [AW-1:0] cur[N];

  initial begin
    a_req  = '0;
    b_req  = '0;
    a_addr = '0;
    b_addr = '0;
    fa[0] = 14'h0042; fa[1] = 14'h1F00; fa[2] = 14'h0123; fa[3] = 14'h3A5C;
    for (int i = 0; i < N; i++) a_addr[i*AW +: AW] = fa[i];

    // Test 1: single request
    tbl.push_back('{rst: 1'b1, req: 4'b0100, gnt: 4'b0100, rv: 4'b0000});
    tbl.push_back('{rst: 1'b0, req: 4'b0000, gnt: 4'b0000, rv: 4'b0100});
    // Test 2: full contention, bursts of four rotating 0..3
    for (int c = 0; c < 20; c++)
      tbl.push_back('{rst: (c == 0), req: 4'b1111, gnt: N'(1) << ((c / 4) % 4),
                      rv: (c == 0) ? 4'b0000 : (N'(1) << (((c - 1) / 4) % 4))});
    tbl.push_back('{rst: 1'b0, req: 4'b0000, gnt: 4'b0000, rv: 4'b0001});
    // Test 3: early release by requester 1 hands over to 3 with no bubble
    tbl.push_back('{rst: 1'b1, req: 4'b0010, gnt: 4'b0010, rv: 4'b0000});
    tbl.push_back('{rst: 1'b0, req: 4'b1010, gnt: 4'b0010, rv: 4'b0010});
    tbl.push_back('{rst: 1'b0, req: 4'b1000, gnt: 4'b1000, rv: 4'b0010});
    for (int c = 0; c < 4; c++)
      tbl.push_back('{rst: 1'b0, req: 4'b1000, gnt: 4'b1000, rv: 4'b1000});
    tbl.push_back('{rst: 1'b0, req: 4'b0000, gnt: 4'b0000, rv: 4'b1000});

    exp_last = '0;
    foreach (tbl[r]) begin
      if (tbl[r].rst) begin
        do_reset();
        exp_last = '0;
      end else begin
        @(negedge clk);
      end
      a_req = tbl[r].req;
      #1;
      chk($sformatf("tbl[%0d] gnt", r), 32'(a_gnt), 32'(tbl[r].gnt));
      chk($sformatf("tbl[%0d] rom_en", r), 32'(a_rom_en), 32'(tbl[r].gnt != 0));
      if (tbl[r].gnt != 0) exp_last = fa[oh2i(tbl[r].gnt)];
      chk($sformatf("tbl[%0d] rom_addr", r), 32'(a_rom_addr), 32'(exp_last));
      chk($sformatf("tbl[%0d] rd_valid", r), 32'(a_rv), 32'(tbl[r].rv));
      if (tbl[r].rv != 0)
        chk($sformatf("tbl[%0d] rd_data", r), 32'(a_rdata), 32'(rom_f(fa[oh2i(tbl[r].rv)])));
    end

    // Test 4: sole requester re-granted every cycle, beat count wraps 1..4
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      a_req = 4'b0001;
      #1;
      chk($sformatf("sole gnt c%0d", k), 32'(a_gnt), 1);
      if (k > 0) chk($sformatf("sole beat c%0d", k), 32'(dut_a.r_beat_cnt), ((k - 1) % 4) + 1);
    end
    @(negedge clk);
    a_req = '0;
    #1;
    chk("sole beat c10", 32'(dut_a.r_beat_cnt), 2);

    // Test 5: reset while a read is in flight on the 3-cycle instance
    do_reset();
    for (int i = 0; i < N; i++) b_addr[i*AW +: AW] = fa[i];
    b_req = 4'b0001;
    #1;
    chk("rst-flight gnt", 32'(b_gnt), 1);
    @(negedge clk);
    b_req = '0;
    rst_n = 1'b0;
    #1;
    chk("rst-flight rv during reset", 32'(b_rv), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst-flight rv c%0d", k), 32'(b_rv), 0);
    end
    b_req = 4'b1111;
    #1;
    chk("rst-flight first gnt", 32'(b_gnt), 1);

    // Test 6: alternating grants through a 3-cycle ROM return in issue order
    do_reset();
    for (int i = 0; i < 6; i++) ta[i] = AW'(14'h0200 + 14'h0111 * i);
    for (int i = 0; i < N; i++) b_cur[i] = '0;
    b_cur[0] = ta[0];
    b_cur[1] = ta[1];
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      b_req = (c < 4) ? 4'b0011 : 4'b0000;
      for (int i = 0; i < N; i++) b_addr[i*AW +: AW] = b_cur[i];
      #1;
      chk($sformatf("lat3 gnt c%0d", c), 32'(b_gnt), (c < 4) ? (1 << (c % 2)) : 0);
      if (c < 4) chk($sformatf("lat3 rom_addr c%0d", c), 32'(b_rom_addr), 32'(ta[c]));
      if (c >= 3 && c < 7) begin
        chk($sformatf("lat3 rv c%0d", c), 32'(b_rv), 1 << ((c - 3) % 2));
        chk($sformatf("lat3 data c%0d", c), 32'(b_rdata), 32'(rom_f(ta[c - 3])));
      end else begin
        chk($sformatf("lat3 rv c%0d", c), 32'(b_rv), 0);
      end
      if (c < 4) b_cur[c % 2] = ta[c + 2];
    end

    // Randomized traffic against a behavioural model of the arbitration rules
    do_reset();
    m_last = -1; m_run = 0; m_ptr = N - 1;
    m_rv = '0; m_raddr = '0; m_alast = '0; prev_gnt = '0;
    for (int i = 0; i < N; i++) cur[i] = fa[i];
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (a_req[i] && !prev_gnt[i]) begin
          if ($urandom_range(15) == 0) a_req[i] = 1'b0;
        end else if ($urandom_range(9) < 6) begin
          a_req[i] = 1'b1;
          cur[i]   = AW'($urandom);
        end else begin
          a_req[i] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) a_addr[i*AW +: AW] = cur[i];
      #1;
      wi     = -1;
      m_keep = (m_last >= 0) && a_req[m_last] && (m_run < MB);
      if (m_keep) wi = m_last;
      else
        for (int k = 1; k <= N; k++)
          if (wi < 0 && a_req[(m_ptr + k) % N]) wi = (m_ptr + k) % N;
      eg    = (wi >= 0) ? (N'(1) << wi) : '0;
      eaddr = (wi >= 0) ? cur[wi] : m_alast;
      chk("rand gnt", 32'(a_gnt), 32'(eg));
      chk("rand rom_en", 32'(a_rom_en), 32'(wi >= 0));
      chk("rand rom_addr", 32'(a_rom_addr), 32'(eaddr));
      chk("rand rd_valid", 32'(a_rv), 32'(m_rv));
      if (m_rv != 0) chk("rand rd_data", 32'(a_rdata), 32'(rom_f(m_raddr)));
      m_rv    = eg;
      m_raddr = eaddr;
      m_alast = eaddr;
      if (m_keep) begin
        m_run++;
      end else if (wi >= 0) begin
        m_last = wi; m_run = 1; m_ptr = wi;
      end else begin
        m_last = -1; m_run = 0;
      end
      prev_gnt = eg;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
